i2s_audio_tx: RTL and testbench
===============================

# i2s_audio_tx

Serializes the 16-bit stereo sample pair produced by the tone generators (square-wave left/right words, e.g. 16'h5FFF / 16'hB000) into an I2S stream for the on-board audio DAC. Sits between the note/buzzer datapath and the DAC pins. Generates all DAC clocks (MCLK, LRCK, SCK) from the 100 MHz system clock, latches one sample pair per frame and shifts it out MSB-first.

## Interface
- RESET_SAMPLE, 16'h0000, value loaded into both sample holding registers on reset
- clk  input  1  system clock, 100 MHz
- rst_n  input  1  reset, asynchronous, active-low
- audio_in_left  input  16  left sample, two's complement
- audio_in_right  input  16  right sample, two's complement
- sample_req  output  1  one-cycle pulse: inputs are captured on the next clk edge
- audio_mclk  output  1  DAC master clock, clk/4
- audio_lrck  output  1  word select, clk/512; 0 = left, 1 = right
- audio_sck  output  1  serial bit clock, clk/16
- audio_sdin  output  1  serial data
- mute  input  1  only present with I2S_TX_MUTE_EN; 1 = transmit zeros

## Operation
- 9-bit free-running counter cnt, +1 every clk, wraps 511 -> 0. Frame = 512 clk.
- audio_mclk = cnt[1], audio_sck = cnt[3], audio_lrck = cnt[8]; taken directly from counter flops (glitch-free).
- Slot index s = cnt[8:4], 0..31, one slot per SCK period. Slots 0-15: left half; 16-31: right half.
- Holding regs hold_l, hold_r: capture audio_in_left/right simultaneously on the edge where cnt == 511. No other capture point; input changes mid-frame have no effect until next frame.
- sample_req = 1 exactly when cnt == 510.
- Frame word F = {hold_l, hold_r} (32 bits). I2S one-bit delay: during slot s (1..31), audio_sdin = F[32 - s] (slot 1 = hold_l[15], slot 16 = hold_l[0], slot 17 = hold_r[15], slot 31 = hold_r[1]); during slot 0, audio_sdin = hold_r[0] of the previous frame.
- Implementation must keep the previous frame's right LSB separately (or use a 33-bit shifter) since hold_r is overwritten at cnt == 511.

## Timing
- audio_sdin is registered; updates only on the clk edge where cnt[3:0] == 4'hF (SCK falling edge), stable across every SCK rising edge.
- Latency: sample captured at cnt==511 of frame N; its left MSB appears on audio_sdin starting cnt==16 of frame N+1 (17 clk after capture).
- Reset values: cnt = 0, hold_l = hold_r = RESET_SAMPLE, previous-LSB reg = 0, audio_sdin = 0, sample_req = 0, audio_mclk = audio_sck = audio_lrck = 0.
- First frame after reset transmits RESET_SAMPLE on both channels; first capture at the 512th clk edge after reset release.
- Reset asserted mid-frame: all state returns to reset values immediately; no partial word completes.
- Counter wrap and capture occur on the same edge; no stall or handshake back-pressure exists (sample_req is advisory only).

## Configuration
- I2S_TX_MUTE_EN defined: mute port exists; mute is sampled at the same cnt==511 edge as the samples; if 1, hold_l and hold_r load 16'h0000 instead of the inputs. Mute asserted mid-frame takes effect at the next frame boundary only.
- Undefined: no mute port; samples always captured unmodified.

## Test plan
- Reset release, inputs 16'hFFFF/16'hFFFF -> first frame sdin all 0 (RESET_SAMPLE=0); lrck period 512 clk, sck period 16, mclk period 4; sample_req high at cnt 510 only.
- left=16'hA5A5, right=16'h5FFF held -> frame N+1 slots 1-16 decode 16'hA5A5, slots 17-31 + next slot 0 decode 16'h5FFF.
- Alternate right 16'h5FFF / 16'hB000 every frame -> slot 0 of each frame carries previous frame's right LSB (1 then 0); no cross-frame corruption.
- Change inputs at cnt=100 then back at cnt=200 -> transmitted frame unaffected; only value at cnt=511 is sent.
- Assert rst_n low at cnt=300 for 3 clk -> all outputs 0 during reset; counting restarts at 0; next frame sends RESET_SAMPLE.
- With I2S_TX_MUTE_EN, left=16'h7FFF, mute=1 at cnt 511 -> next frame all zeros; mute=0 -> following frame carries 16'h7FFF.

Source files
------------

// File: rtl/i2s_audio_tx_if.sv
// rtl/i2s_audio_tx_if.sv - sample-side bus between tone datapath and I2S transmitter
// Optional mute signal is present only when I2S_TX_MUTE_EN is defined.
interface i2s_audio_tx_if;
  logic [15:0] audio_in_left;
  logic [15:0] audio_in_right;
  logic        sample_req;
`ifdef I2S_TX_MUTE_EN
  logic        mute;

  modport master (output audio_in_left, output audio_in_right, output mute, input sample_req);
  modport slave  (input audio_in_left, input audio_in_right, input mute, output sample_req);
`else
  modport master (output audio_in_left, output audio_in_right, input sample_req);
  modport slave  (input audio_in_left, input audio_in_right, output sample_req);
`endif
endinterface

// File: rtl/i2s_audio_tx.sv
// rtl/i2s_audio_tx.sv - 16-bit stereo I2S serializer with DAC clock generation
// Optional feature macro: I2S_TX_MUTE_EN (adds mute on the sample bus).
module i2s_audio_tx #(
  parameter logic [15:0] RESET_SAMPLE = 16'h0000
) (
  input  logic            clk,
  input  logic            rst_n,
  i2s_audio_tx_if.slave   bus,
  output logic            audio_mclk,
  output logic            audio_lrck,
  output logic            audio_sck,
  output logic            audio_sdin
);

  logic [8:0]  cnt;
  logic [15:0] hold_l;
  logic [15:0] hold_r;
  logic        sdin_q;
  logic        req_q;

  logic [15:0] cap_l;
  logic [15:0] cap_r;
  logic [31:0] frame_word;
  logic [4:0]  next_slot;
  logic [4:0]  bit_idx;
  logic        frame_end;
  logic        slot_end;

  assign frame_end  = (cnt == 9'd511);
  assign slot_end   = (cnt[3:0] == 4'hF);
  assign frame_word = {hold_l, hold_r};
  assign next_slot  = cnt[8:4] + 5'd1;
  // Slot n carries F[32-n]; modulo 32 this maps slot 0 onto F[0], i.e. the
  // right LSB still sitting in hold_r on the wrap edge, before it is replaced.
  // The sdin flop therefore carries the previous frame's LSB into slot 0.
  assign bit_idx    = 5'd0 - next_slot;

  // Values loaded into the holding registers at the frame boundary.
  always_comb begin
    cap_l = bus.audio_in_left;
    cap_r = bus.audio_in_right;
`ifdef I2S_TX_MUTE_EN
    if (bus.mute) begin
      cap_l = 16'h0000;
      cap_r = 16'h0000;
    end
`endif
  end

  // Free-running frame counter; all DAC clocks are bits of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= 9'd0;
    else        cnt <= cnt + 9'd1;
  end

  // Capture one stereo pair per frame on the wrap edge only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_l <= RESET_SAMPLE;
      hold_r <= RESET_SAMPLE;
    end else if (frame_end) begin
      hold_l <= cap_l;
      hold_r <= cap_r;
    end
  end

  // Serial data changes only on the SCK falling edge (end of each slot).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        sdin_q <= 1'b0;
    else if (slot_end) sdin_q <= frame_word[bit_idx];
  end

  // Request pulse registered one cycle ahead so it is high exactly at cnt == 510.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) req_q <= 1'b0;
    else        req_q <= (cnt == 9'd509);
  end

  assign audio_mclk     = cnt[1];
  assign audio_sck      = cnt[3];
  assign audio_lrck     = cnt[8];
  assign audio_sdin     = sdin_q;
  assign bus.sample_req = req_q;

endmodule

// File: tb/tb_i2s_audio_tx.sv
// tb/tb_i2s_audio_tx.sv - directed self-checking bench for i2s_audio_tx
module tb_i2s_audio_tx;

  logic clk;
  logic rst_n;
  logic audio_mclk, audio_lrck, audio_sck, audio_sdin;

  i2s_audio_tx_if bus ();

  i2s_audio_tx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .audio_mclk (audio_mclk),
    .audio_lrck (audio_lrck),
    .audio_sck  (audio_sck),
    .audio_sdin (audio_sdin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int clk_err  = 0;
  logic [8:0] cyc = 9'd0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock; track expected counter and verify derived clocks.
  task automatic tick();
    @(posedge clk);
    #1;
    if (!rst_n) cyc = 9'd0;
    else        cyc = cyc + 9'd1;
    if (audio_mclk !== cyc[1]) clk_err++;
    if (audio_sck  !== cyc[3]) clk_err++;
    if (audio_lrck !== cyc[8]) clk_err++;
    if (bus.sample_req !== (cyc == 9'd510)) clk_err++;
  endtask

  task automatic tick_to(input logic [8:0] target);
    for (int i = 0; i < 600 && cyc != target; i++) tick();
  endtask

  // Collect one frame: rx[s] is the bit sampled mid-slot s. Entered at cyc == 0.
  task automatic get_frame(output logic [31:0] rx);
    rx = '0;
    for (int s = 0; s < 32; s++) begin
      tick_to(9'(s * 16 + 8));
      rx[s] = audio_sdin;
    end
    tick_to(9'd0);
  endtask

  function automatic logic [15:0] dec_left(input logic [31:0] rx);
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[15 - i] = rx[1 + i];
    return v;
  endfunction

  function automatic logic [15:0] dec_right(input logic [31:0] rx, input logic [31:0] rx_next);
    logic [15:0] v;
    for (int i = 0; i < 15; i++) v[15 - i] = rx[17 + i];
    v[0] = rx_next[0];
    return v;
  endfunction

  logic [31:0] f0, f1, f2, f3, f5, f7, f8, f9;
  logic        s0;

  initial begin
    rst_n = 1'b0;
    bus.audio_in_left  = 16'hFFFF;
    bus.audio_in_right = 16'hFFFF;
`ifdef I2S_TX_MUTE_EN
    bus.mute = 1'b0;
`endif
    tick(); tick(); tick();
    check_eq("reset_outputs",
             {27'd0, audio_sdin, audio_lrck, audio_sck, audio_mclk, bus.sample_req}, 32'd0);

    rst_n = 1'b1;
    get_frame(f0);
    check_eq("frame0_reset_sample", f0, 32'h0000_0000);

    bus.audio_in_left  = 16'hA5A5;
    bus.audio_in_right = 16'h5FFF;
    get_frame(f1);
    check_eq("frame1_ffff", f1, 32'hFFFF_FFFE);

    bus.audio_in_right = 16'hB000;
    get_frame(f2);
    check_eq("f2_left", {16'd0, dec_left(f2)}, 32'h0000_A5A5);
    check_eq("f2_slot0", {31'd0, f2[0]}, 32'd1);

    bus.audio_in_right = 16'h5FFF;
    get_frame(f3);
    check_eq("f2_right", {16'd0, dec_right(f2, f3)}, 32'h0000_5FFF);
    check_eq("f3_left", {16'd0, dec_left(f3)}, 32'h0000_A5A5);
    check_eq("f3_slot0", {31'd0, f3[0]}, 32'd1);

    // Frame 4: mid-frame input changes; only the cnt==511 value is sent.
    tick_to(9'd8);
    s0 = audio_sdin;
    check_eq("f4_slot0", {31'd0, s0}, 32'd0);
    check_eq("f3_right_hi", {17'd0, dec_right(f3, {31'd0, s0}) >> 1}, 32'h0000_5800);
    tick_to(9'd100);
    bus.audio_in_left  = 16'h0000;
    bus.audio_in_right = 16'h0000;
    tick_to(9'd200);
    bus.audio_in_left  = 16'h1234;
    bus.audio_in_right = 16'h5678;
    tick_to(9'd0);

    get_frame(f5);
    check_eq("f5_left", {16'd0, dec_left(f5)}, 32'h0000_1234);
    check_eq("f5_slot0", {31'd0, f5[0]}, 32'd1);

    // Frame 6: reset asserted at cnt 300 for 3 clocks.
    tick_to(9'd8);
    check_eq("f5_right", {16'd0, dec_right(f5, {31'd0, audio_sdin})}, 32'h0000_5678);
    tick_to(9'd300);
    check_eq("lrck_before_reset", {31'd0, audio_lrck}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("midframe_reset_outputs",
             {27'd0, audio_sdin, audio_lrck, audio_sck, audio_mclk, bus.sample_req}, 32'd0);
    tick(); tick(); tick();
    rst_n = 1'b1;
    get_frame(f7);
    check_eq("f7_after_reset", f7, 32'h0000_0000);

`ifdef I2S_TX_MUTE_EN
    bus.audio_in_left = 16'h7FFF;
    bus.mute = 1'b1;
`endif
    get_frame(f8);
    check_eq("f8_left", {16'd0, dec_left(f8)}, 32'h0000_1234);
    check_eq("f8_slot0", {31'd0, f8[0]}, 32'd0);

`ifdef I2S_TX_MUTE_EN
    bus.mute = 1'b0;
`endif
    get_frame(f9);
    check_eq("f8_right", {16'd0, dec_right(f8, f9)}, 32'h0000_5678);
`ifdef I2S_TX_MUTE_EN
    check_eq("f9_muted", f9, 32'h0000_0000);
    get_frame(f9);
    check_eq("f10_unmuted_left", {16'd0, dec_left(f9)}, 32'h0000_7FFF);
`endif

    check_eq("clock_and_req_errors", clk_err, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
